// File: rtl/heroe_pkg.sv
// Shared definitions for the game control blocks: scheduler states, game codes, key codes and helpers.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package heroe_pkg;

  // Obstacle scheduler control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } sched_state_e;

  // Game FSM state code in which obstacles are generated
  localparam logic [2:0] PLAY_CODE = 3'd3;

  // Decoded keypad code that toggles pause
  localparam logic [4:0] PAUSE_KEY = 5'h0F;

  // W_or_L encodings; 2'b11 is handled like a loss (any non-play value halts)
  localparam logic [1:0] WL_PLAY = 2'b00;
  localparam logic [1:0] WL_WIN  = 2'b01;
  localparam logic [1:0] WL_LOSE = 2'b10;

  // Width of the step period counter; wide enough for the 25M-cycle default
  localparam int unsigned PERIOD_W = 32;

  localparam logic [9:0] SCORE_MAX = 10'd999;
  localparam logic [2:0] NIVEL_MAX = 3'd7;

  // Step period for a given level: base minus one reduction per level,
  // never below the floor.
  function automatic logic [PERIOD_W-1:0] calc_period(
    input int unsigned base,
    input int unsigned step,
    input int unsigned minp,
    input logic [2:0]  nivel
  );
    logic [PERIOD_W-1:0] red;
    red = 32'(nivel) * step;
    if (red + minp > base) begin
      return minp;
    end
    return base - red;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Period counter: counts 0..period-1 while enabled, holds otherwise, clear has priority.
// Latency: wrap is combinational from the counter register (high while the count sits at period-1).
// Backpressure: none; the owner decides per cycle whether to advance (en) or hold.
module tick_divider #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Terminal count; >= keeps the counter from running away if the period ever shrinks below it
  assign wrap = (cnt_q >= period - ONE);

  // Next count: clear, else advance-and-wrap when enabled, else hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + ONE;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Paces the obstacle generator: step pulse every period, level speed-up, pause/halt control, score.
// Latency: all outputs registered; step rises one cycle after the counter sits at period-1 in RUN.
// Backpressure: none; pause key and W_or_L hold the pacing, score build selected by OBSTACLE_SCHEDULER_SCORE_EN.
module obstacle_scheduler
  import heroe_pkg::*;
#(
  parameter int unsigned BASE_PERIOD     = 25_000_000,
  parameter int unsigned PERIOD_STEP     = 2_500_000,
  parameter int unsigned MIN_PERIOD      = 5_000_000,
  parameter int unsigned STEPS_PER_LEVEL = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] presente,
  input  logic [1:0] W_or_L,
  input  logic       keypad_pressed,
  input  logic [4:0] key,
  output logic       step,
  output logic [2:0] nivel,
  output logic       level_up,
  output logic [9:0] score,
  output logic       paused
);

  sched_state_e state_q, state_d;

  logic          step_q, step_d;
  logic          level_up_q, level_up_d;
  logic [2:0]    nivel_q, nivel_d;
  logic          paused_q, paused_d;
  logic [31:0]   lvl_cnt_q, lvl_cnt_d;
  logic          kp_q, kp_d;

  logic [PERIOD_W-1:0] period;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_wrap;
  logic          adv;
  logic          play_ok;
  logic          wl_play;
  logic          pause_edge;

  assign play_ok    = (presente == PLAY_CODE);
  assign wl_play    = (W_or_L == WL_PLAY);
  // Only a fresh press of the pause key counts; held keys and other codes are ignored
  assign pause_edge = keypad_pressed && !kp_q && (key == PAUSE_KEY);

  // Period follows the registered level, so a level change applies from the next step on
  assign period = calc_period(BASE_PERIOD, PERIOD_STEP, MIN_PERIOD, nivel_q);

  tick_divider #(
    .W(PERIOD_W)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .period (period),
    .wrap   (cnt_wrap)
  );

  // Next-state, counter control and level bookkeeping
  always_comb begin
    state_d    = state_q;
    step_d     = 1'b0;
    level_up_d = 1'b0;
    nivel_d    = nivel_q;
    lvl_cnt_d  = lvl_cnt_q;
    kp_d       = keypad_pressed;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    adv        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (play_ok && wl_play) begin
          state_d   = ST_RUN;
          nivel_d   = '0;
          lvl_cnt_d = '0;
          cnt_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!play_ok) begin
          state_d = ST_IDLE;
        end else if (!wl_play) begin
          state_d = ST_HALT;
        end else if (pause_edge) begin
          // Pause wins over a wrap in the same cycle: hold at period-1 so
          // the pending step fires right after resume.
          state_d = ST_PAUSE;
          cnt_en  = !cnt_wrap;
        end else begin
          cnt_en = 1'b1;
          adv    = cnt_wrap;
        end
      end
      ST_PAUSE: begin
        if (!play_ok) begin
          state_d = ST_IDLE;
        end else if (!wl_play) begin
          state_d = ST_HALT;
        end else if (pause_edge) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (!play_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (adv) begin
      step_d = 1'b1;
      if (lvl_cnt_q >= STEPS_PER_LEVEL - 1) begin
        lvl_cnt_d = '0;
        if (nivel_q != NIVEL_MAX) begin
          nivel_d    = nivel_q + 3'd1;
          level_up_d = 1'b1;
        end
      end else begin
        lvl_cnt_d = lvl_cnt_q + 32'd1;
      end
    end

    paused_d = (state_d == ST_PAUSE);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= 1'b0;
      level_up_q <= 1'b0;
      nivel_q    <= '0;
      paused_q   <= 1'b0;
      lvl_cnt_q  <= '0;
      kp_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      level_up_q <= level_up_d;
      nivel_q    <= nivel_d;
      paused_q   <= paused_d;
      lvl_cnt_q  <= lvl_cnt_d;
      kp_q       <= kp_d;
    end
  end

`ifdef OBSTACLE_SCHEDULER_SCORE_EN
  logic [9:0] score_q, score_d;
  logic       score_clr;

  assign score_clr = (state_q == ST_IDLE) && (state_d == ST_RUN);

  // Score: cleared on round entry, one per step, saturating
  always_comb begin
    score_d = score_q;
    if (score_clr) begin
      score_d = '0;
    end else if (adv && (score_q != SCORE_MAX)) begin
      score_d = score_q + 10'd1;
    end
  end

  // Score register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

  assign step     = step_q;
  assign level_up = level_up_q;
  assign nivel    = nivel_q;
  assign paused   = paused_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler with short periods (10/2/4, 3 steps per level).
// Latency: gaps measured in clk cycles between negedge samples of step.
// Backpressure: not applicable.
module tb_obstacle_scheduler;

`ifdef OBSTACLE_SCHEDULER_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] presente;
  logic [1:0] W_or_L;
  logic       keypad_pressed;
  logic [4:0] key;
  logic       step;
  logic [2:0] nivel;
  logic       level_up;
  logic [9:0] score;
  logic       paused;

  always #5 clk = ~clk;

  obstacle_scheduler #(
    .BASE_PERIOD     (10),
    .PERIOD_STEP     (2),
    .MIN_PERIOD      (4),
    .STEPS_PER_LEVEL (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .presente       (presente),
    .W_or_L         (W_or_L),
    .keypad_pressed (keypad_pressed),
    .key            (key),
    .step           (step),
    .nivel          (nivel),
    .level_up       (level_up),
    .score          (score),
    .paused         (paused)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int gap;
    int nivel;
    int lu;
    int score;
  } vec_t;

  vec_t tbl[9];

  function automatic int es(input int s);
    return SCORE_ON ? s : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles until step is seen high; -1 if it never comes within limit
  task automatic wait_step(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step !== 1'b1 && n < limit);
    if (step !== 1'b1) n = -1;
  endtask

  // Number of step pulses seen over a window of n cycles
  task automatic count_steps(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (step === 1'b1) c++;
    end
  endtask

  initial begin
    int g;
    int c;
    int lus;
    int unp;

    tbl = '{
      '{11, 0, 0, 1},
      '{10, 0, 0, 2},
      '{10, 1, 1, 3},
      '{ 8, 1, 0, 4},
      '{ 8, 1, 0, 5},
      '{ 8, 2, 1, 6},
      '{ 6, 2, 0, 7},
      '{ 6, 2, 0, 8},
      '{ 6, 3, 1, 9}
    };

    rst_n = 1'b0; presente = 3'd0; W_or_L = 2'b00; keypad_pressed = 1'b0; key = 5'h00;
    tick(3);
    chk("rst_step", step, 0);
    chk("rst_level_up", level_up, 0);
    chk("rst_nivel", nivel, 0);
    chk("rst_score", score, 0);
    chk("rst_paused", paused, 0);

    // Round 1: basic pacing and level-ups
    rst_n = 1'b1; presente = 3'd3;
    for (int i = 0; i < 9; i++) begin
      wait_step(50, g);
      chk($sformatf("gap_%0d", i + 1), g, tbl[i].gap);
      chk($sformatf("nivel_%0d", i + 1), nivel, tbl[i].nivel);
      chk($sformatf("level_up_%0d", i + 1), level_up, tbl[i].lu);
      chk($sformatf("score_%0d", i + 1), score, es(tbl[i].score));
    end

    // Period at floor, level saturating at 7
    for (int s = 10; s <= 30; s++) begin
      wait_step(50, g);
      chk($sformatf("floor_gap_%0d", s), g, 4);
      chk($sformatf("floor_nivel_%0d", s), nivel, (s / 3 > 7) ? 7 : s / 3);
      chk($sformatf("floor_lu_%0d", s), level_up, (s % 3 == 0 && s <= 21) ? 1 : 0);
    end

    // Long run for score saturation
    c = 0; lus = 0;
    repeat (4100) begin
      @(negedge clk);
      if (step === 1'b1) c++;
      if (level_up === 1'b1) lus++;
    end
    chk("long_steps", c, 1025);
    chk("long_level_ups", lus, 0);
    chk("long_score_sat", score, es(999));
    chk("long_nivel", nivel, 7);

    // Leave the game: values hold in IDLE, cleared on re-entry
    presente = 3'd0;
    count_steps(3, c);
    chk("idle_no_step", c, 0);
    chk("idle_nivel_hold", nivel, 7);
    chk("idle_score_hold", score, es(999));
    presente = 3'd3;
    tick(1);
    chk("entry_nivel_clr", nivel, 0);
    chk("entry_score_clr", score, 0);
    wait_step(50, g);
    chk("r2_gap1", g, 10);
    chk("r2_score1", score, es(1));

    // Pause at count 4, hold for 20 cycles, resume
    tick(4);
    keypad_pressed = 1'b1; key = 5'h0F;
    tick(1);
    chk("pause_paused", paused, 1);
    chk("pause_step", step, 0);
    c = 0; unp = 0;
    repeat (20) begin
      @(negedge clk);
      if (step === 1'b1) c++;
      if (paused !== 1'b1) unp++;
    end
    chk("pause_held_steps", c, 0);
    chk("pause_held_unpaused", unp, 0);
    keypad_pressed = 1'b0;
    tick(1);
    chk("pause_release_paused", paused, 1);
    keypad_pressed = 1'b1;
    wait_step(50, g);
    chk("resume_gap", g, 6);
    chk("resume_paused", paused, 0);
    chk("resume_score", score, es(2));
    keypad_pressed = 1'b0;

    // Pause edge on the wrap cycle
    tick(9);
    keypad_pressed = 1'b1;
    tick(1);
    chk("wrap_pause_step", step, 0);
    chk("wrap_pause_paused", paused, 1);
    keypad_pressed = 1'b0;
    count_steps(3, c);
    chk("wrap_pause_no_step", c, 0);
    keypad_pressed = 1'b1;
    wait_step(50, g);
    chk("wrap_resume_gap", g, 2);
    chk("wrap_resume_nivel", nivel, 1);
    chk("wrap_resume_level_up", level_up, 1);
    chk("wrap_resume_score", score, es(3));
    keypad_pressed = 1'b0;

    // Non-pause key edges are ignored (period now 8)
    key = 5'h05; keypad_pressed = 1'b1;
    tick(1);
    keypad_pressed = 1'b0;
    tick(1);
    keypad_pressed = 1'b1;
    tick(1);
    chk("key05_paused", paused, 0);
    wait_step(50, g);
    chk("key05_gap", g, 5);
    chk("key05_score", score, es(4));
    keypad_pressed = 1'b0;

    // Loss on the wrap cycle: step suppressed, then frozen
    tick(7);
    W_or_L = 2'b10;
    count_steps(30, c);
    chk("halt_no_step", c, 0);
    chk("halt_score", score, es(4));
    chk("halt_nivel", nivel, 1);

    presente = 3'd0;
    tick(1);
    W_or_L = 2'b00; presente = 3'd3;
    tick(1);
    chk("r3_nivel_clr", nivel, 0);
    chk("r3_score_clr", score, 0);

    // Reset while paused
    wait_step(50, g);
    chk("r3_gap1", g, 10);
    chk("r3_score1", score, es(1));
    tick(3);
    key = 5'h0F; keypad_pressed = 1'b1;
    tick(1);
    chk("r3_paused", paused, 1);
    rst_n = 1'b0;
    tick(1);
    chk("rstp_step", step, 0);
    chk("rstp_paused", paused, 0);
    chk("rstp_score", score, 0);
    chk("rstp_nivel", nivel, 0);
    chk("rstp_level_up", level_up, 0);
    rst_n = 1'b1; keypad_pressed = 1'b0;
    wait_step(50, g);
    chk("rstp_restart_gap", g, 11);
    chk("rstp_restart_paused", paused, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
